// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU tile sequencers (master_input_ctrl and
// master_output_ctrl): the controller state enum and index-width helpers.
package tpu_ctrl_pkg;

    // Width of an index able to address n items; never narrower than one bit
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end
        return 1;
    endfunction

    localparam int DEF_MAX_OUT_ROWS = 128;
    localparam int DEF_MAX_OUT_COLS = 128;
    localparam int DEF_SYS_ARR_ROWS = 16;
    localparam int DEF_SYS_ARR_COLS = 16;

    localparam int LANE_IDX_W = idx_width(DEF_SYS_ARR_ROWS);
    localparam int SUBM_ROW_W = idx_width(DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS);
    localparam int SUBM_COL_W = idx_width(DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FEED    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_HANDOFF = 3'd3,
        ST_WAIT    = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/master_input_ctrl_if.sv
// Tile request, input-buffer read bus and output-controller handshake of
// master_input_ctrl. The master modport is the sequencer's view.
interface master_input_ctrl_if
    import tpu_ctrl_pkg::*;
#(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8
) ();

    localparam int LANE_W = idx_width(SYS_ARR_ROWS);
    localparam int ROW_W  = idx_width(MAX_OUT_ROWS / SYS_ARR_ROWS);
    localparam int COL_W  = idx_width(MAX_OUT_COLS / SYS_ARR_COLS);

    logic                               start;
    logic [ADDR_WIDTH-1:0]              rd_base_addr;
    logic [LANE_W-1:0]                  vec_last;
    logic [LANE_W-1:0]                  lane_last;
    logic [ROW_W-1:0]                   submatrix_row_in;
    logic [COL_W-1:0]                   submatrix_col_in;
    logic                               out_done;

    logic [SYS_ARR_ROWS-1:0]            rd_en;
    logic [ADDR_WIDTH*SYS_ARR_ROWS-1:0] rd_addr;
    logic                               out_start;
    logic [LANE_W-1:0]                  out_rows_num;
    logic [ROW_W-1:0]                   submatrix_row_out;
    logic [COL_W-1:0]                   submatrix_col_out;
    logic                               done;

    modport master (
        input  start, rd_base_addr, vec_last, lane_last,
               submatrix_row_in, submatrix_col_in, out_done,
        output rd_en, rd_addr, out_start, out_rows_num,
               submatrix_row_out, submatrix_col_out, done
    );

    modport slave (
        output start, rd_base_addr, vec_last, lane_last,
               submatrix_row_in, submatrix_col_in, out_done,
        input  rd_en, rd_addr, out_start, out_rows_num,
               submatrix_row_out, submatrix_col_out, done
    );

endinterface

// File: rtl/master_input_ctrl_skew_addr_gen.sv
// Combinational per-lane read enable/address generator. Lane i starts i
// cycles after lane 0 so activations enter the array diagonally skewed.
module skew_addr_gen
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int SYS_ARR_ROWS = 16,
    parameter int LANE_W       = idx_width(SYS_ARR_ROWS),
    parameter int T_W          = LANE_W + 1
) (
    input  logic [T_W-1:0]                   t,
    input  logic [ADDR_WIDTH-1:0]            base,
    input  logic [LANE_W-1:0]                vec_last,
    input  logic [LANE_W-1:0]                lane_last,
    output logic [SYS_ARR_ROWS-1:0]          lane_en,
    output logic [ADDR_WIDTH*SYS_ARR_ROWS-1:0] lane_addr
);

    // Lane i streams vectors 0..vec_last during feed steps i..i+vec_last; address wraps
    always_comb begin
        lane_en   = '0;
        lane_addr = '0;
        for (int i = 0; i < SYS_ARR_ROWS; i++) begin
            if ((i <= int'(lane_last)) && (int'(t) >= i) &&
                (int'(t) <= i + int'(vec_last))) begin
                lane_en[i] = 1'b1;
                lane_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = base + ADDR_WIDTH'(int'(t) - i);
            end
        end
    end

endmodule

// File: rtl/master_input_ctrl.sv
// Tile sequencer in front of the systolic array: latches a tile descriptor,
// issues skewed per-lane input-buffer reads, waits for the array to drain,
// then hands the tile to the output controller and waits for it to finish.
module master_input_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    master_input_ctrl_if.master  bus
);

    localparam int LANE_W       = idx_width(SYS_ARR_ROWS);
    localparam int T_W          = LANE_W + 1;
    localparam int ROW_W        = idx_width(MAX_OUT_ROWS / SYS_ARR_ROWS);
    localparam int COL_W        = idx_width(MAX_OUT_COLS / SYS_ARR_COLS);
    localparam int DRAIN_CYCLES = SYS_ARR_COLS + RD_LATENCY;
    localparam int DRAIN_W      = idx_width(DRAIN_CYCLES + 1);

    ctrl_state_e             state_q;
    ctrl_state_e             state_d;
    logic [T_W-1:0]          feed_cnt_q;
    logic [DRAIN_W-1:0]      drain_cnt_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [LANE_W-1:0]       vec_last_q;
    logic [LANE_W-1:0]       lane_last_q;
    logic [ROW_W-1:0]        sub_row_q;
    logic [COL_W-1:0]        sub_col_q;

    logic                    accept;
    logic [T_W-1:0]          feed_end;
    logic                    feed_last;
    logic                    drain_last;
    logic [SYS_ARR_ROWS-1:0] gen_en;
    logic [ADDR_WIDTH*SYS_ARR_ROWS-1:0] gen_addr;

    assign accept     = (state_q == ST_IDLE) && bus.start;
    assign feed_end   = {1'b0, vec_last_q} + {1'b0, lane_last_q};
    assign feed_last  = (feed_cnt_q == feed_end);
    assign drain_last = (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1));

    // State register; reset aborts any tile in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start is only looked at in IDLE, so it never queues
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start)   state_d = ST_FEED;
            ST_FEED:    if (feed_last)   state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_last)  state_d = ST_HANDOFF;
            ST_HANDOFF:                  state_d = ST_WAIT;
            ST_WAIT:    if (bus.out_done) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Feed step t and drain counter only run in their own state, else held at 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            feed_cnt_q  <= (state_q == ST_FEED)  ? feed_cnt_q + 1'b1  : '0;
            drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : '0;
        end
    end

    // Descriptor is captured on acceptance and held until the next one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q      <= '0;
            vec_last_q  <= '0;
            lane_last_q <= '0;
            sub_row_q   <= '0;
            sub_col_q   <= '0;
        end else if (accept) begin
            base_q      <= bus.rd_base_addr;
            vec_last_q  <= bus.vec_last;
            lane_last_q <= bus.lane_last;
            sub_row_q   <= bus.submatrix_row_in;
            sub_col_q   <= bus.submatrix_col_in;
        end
    end

    skew_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .SYS_ARR_ROWS (SYS_ARR_ROWS),
        .LANE_W       (LANE_W),
        .T_W          (T_W)
    ) u_skew_addr_gen (
        .t         (feed_cnt_q),
        .base      (base_q),
        .vec_last  (vec_last_q),
        .lane_last (lane_last_q),
        .lane_en   (gen_en),
        .lane_addr (gen_addr)
    );

    // Read bus is only live during FEED; everything here comes from registers
    assign bus.rd_en             = (state_q == ST_FEED) ? gen_en   : '0;
    assign bus.rd_addr           = (state_q == ST_FEED) ? gen_addr : '0;
    assign bus.out_start         = (state_q == ST_HANDOFF);
    assign bus.done              = (state_q == ST_IDLE);
    assign bus.out_rows_num      = vec_last_q;
    assign bus.submatrix_row_out = sub_row_q;
    assign bus.submatrix_col_out = sub_col_q;

endmodule

// File: tb/tb_master_input_ctrl.sv
// Self-checking bench for master_input_ctrl with a 4x4 array and one-cycle
// buffer latency: per-cycle vector table plus directed handshake, reset and
// back-to-back sequences.
module tb_master_input_ctrl;

    localparam int AW   = 8;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int RDL  = 1;
    localparam int MOR  = 128;
    localparam int MOC  = 128;

    typedef struct {
        logic        start;
        logic [7:0]  base;
        logic [1:0]  vl;
        logic [1:0]  ll;
        logic        od;
        logic [3:0]  en;
        logic [31:0] addr;
        logic        os;
        logic        dn;
        logic [1:0]  rows;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    master_input_ctrl_if #(
        .MAX_OUT_ROWS (MOR), .MAX_OUT_COLS (MOC),
        .SYS_ARR_ROWS (ROWS), .SYS_ARR_COLS (COLS), .ADDR_WIDTH (AW)
    ) bus ();

    master_input_ctrl #(
        .MAX_OUT_ROWS (MOR), .MAX_OUT_COLS (MOC),
        .SYS_ARR_ROWS (ROWS), .SYS_ARR_COLS (COLS),
        .ADDR_WIDTH (AW), .RD_LATENCY (RDL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_accept(input logic [7:0] b, input logic [1:0] vl, input logic [1:0] ll,
                               input logic [1:0] rows_prev);
        vec_t v;
        v.start = 1'b1; v.base = b; v.vl = vl; v.ll = ll; v.od = 1'b1;
        v.en = '0; v.addr = '0; v.os = 1'b0; v.dn = 1'b1; v.rows = rows_prev;
        vecs.push_back(v);
    endtask

    task automatic push_cyc(input logic od, input logic [3:0] en, input logic [31:0] addr,
                            input logic os, input logic dn, input logic [1:0] rows);
        vec_t v;
        v.start = 1'b0; v.base = '0; v.vl = '0; v.ll = '0; v.od = od;
        v.en = en; v.addr = addr; v.os = os; v.dn = dn; v.rows = rows;
        vecs.push_back(v);
    endtask

    // Tail common to every tile: DRAIN (5 cycles), HANDOFF, two WAIT cycles, IDLE
    task automatic push_tail(input logic [1:0] rows);
        for (int k = 0; k < COLS + RDL; k++) push_cyc(1'b1, 4'b0, 32'h0, 1'b0, 1'b0, rows);
        push_cyc(1'b1, 4'b0, 32'h0, 1'b1, 1'b0, rows);
        push_cyc(1'b0, 4'b0, 32'h0, 1'b0, 1'b0, rows);
        push_cyc(1'b1, 4'b0, 32'h0, 1'b0, 1'b0, rows);
        push_cyc(1'b1, 4'b0, 32'h0, 1'b0, 1'b1, rows);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.start            = v.start;
        bus.rd_base_addr     = v.base;
        bus.vec_last         = v.vl;
        bus.lane_last        = v.ll;
        bus.out_done         = v.od;
        bus.submatrix_row_in = '0;
        bus.submatrix_col_in = '0;
    endtask

    task automatic check_output(input string tag, input int i, input vec_t v);
        check_val($sformatf("%s[%0d].rd_en", tag, i), 32'(bus.rd_en), 32'(v.en));
        check_val($sformatf("%s[%0d].rd_addr", tag, i), bus.rd_addr, v.addr);
        check_val($sformatf("%s[%0d].out_start", tag, i), 32'(bus.out_start), 32'(v.os));
        check_val($sformatf("%s[%0d].done", tag, i), 32'(bus.done), 32'(v.dn));
        check_val($sformatf("%s[%0d].out_rows_num", tag, i), 32'(bus.out_rows_num), 32'(v.rows));
    endtask

    task automatic run_vectors(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output(tag, i, vecs[i]);
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, ".rd_en"}, 32'(bus.rd_en), 32'h0);
        check_val({tag, ".rd_addr"}, bus.rd_addr, 32'h0);
        check_val({tag, ".out_start"}, 32'(bus.out_start), 32'h0);
        check_val({tag, ".done"}, 32'(bus.done), 32'h1);
        check_val({tag, ".out_rows_num"}, 32'(bus.out_rows_num), 32'h0);
        check_val({tag, ".sub_row"}, 32'(bus.submatrix_row_out), 32'h0);
        check_val({tag, ".sub_col"}, 32'(bus.submatrix_col_out), 32'h0);
    endtask

    initial begin
        int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;
        int cyc;
        bit found, held_ok, prev_os, saw_os;

        // Tile A: base 0x10, 4 vectors, 4 lanes
        a_lo = vecs.size();
        push_accept(8'h10, 2'd3, 2'd3, 2'd0);
        push_cyc(1'b1, 4'b0001, 32'h0000_0010, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b0011, 32'h0000_1011, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b0111, 32'h0010_1112, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b1111, 32'h1011_1213, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b1110, 32'h1112_1300, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b1100, 32'h1213_0000, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b1000, 32'h1300_0000, 1'b0, 1'b0, 2'd3);
        push_tail(2'd3);
        a_hi = vecs.size() - 1;

        // Tile B: partial, 2 vectors on 2 lanes
        b_lo = vecs.size();
        push_accept(8'h20, 2'd1, 2'd1, 2'd3);
        push_cyc(1'b1, 4'b0001, 32'h0000_0020, 1'b0, 1'b0, 2'd1);
        push_cyc(1'b1, 4'b0011, 32'h0000_2021, 1'b0, 1'b0, 2'd1);
        push_cyc(1'b1, 4'b0010, 32'h0000_2100, 1'b0, 1'b0, 2'd1);
        push_tail(2'd1);
        b_hi = vecs.size() - 1;

        // Tile C: single lane whose addresses wrap past 0xFF
        c_lo = vecs.size();
        push_accept(8'hFE, 2'd3, 2'd0, 2'd1);
        push_cyc(1'b1, 4'b0001, 32'h0000_00FE, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b0001, 32'h0000_00FF, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b0001, 32'h0000_0000, 1'b0, 1'b0, 2'd3);
        push_cyc(1'b1, 4'b0001, 32'h0000_0001, 1'b0, 1'b0, 2'd3);
        push_tail(2'd3);
        c_hi = vecs.size() - 1;

        // Power-up reset
        bus.start = 1'b0; bus.rd_base_addr = '0; bus.vec_last = '0; bus.lane_last = '0;
        bus.submatrix_row_in = '0; bus.submatrix_col_in = '0; bus.out_done = 1'b1;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_values("por");
        step();
        reset = 1'b1;

        run_vectors(a_lo, a_hi, "tileA");
        run_vectors(b_lo, b_hi, "tileB");
        run_vectors(c_lo, c_hi, "tileC");

        // Handshake: output controller stays busy 10 cycles, start in WAIT ignored
        bus.start = 1'b1; bus.rd_base_addr = 8'h40; bus.vec_last = '0; bus.lane_last = '0;
        bus.submatrix_row_in = 5'd3; bus.submatrix_col_in = 5'd4; bus.out_done = 1'b1;
        step();
        bus.start = 1'b0; bus.submatrix_row_in = '0; bus.submatrix_col_in = '0;
        cyc = 1;
        found = 1'b0;
        while (cyc <= 20 && !found) begin
            @(negedge clk);
            if (bus.out_start) found = 1'b1;
            else begin cyc++; step(); end
        end
        check_val("hs.out_start_cycle", 32'(cyc), 32'd7);
        step();
        bus.out_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.start = (k == 4);
            bus.submatrix_row_in = 5'd6; bus.submatrix_col_in = 5'd7; bus.vec_last = 2'd2;
            @(negedge clk);
            check_val($sformatf("hs.wait%0d.done", k), 32'(bus.done), 32'h0);
            step();
        end
        bus.start = 1'b0; bus.out_done = 1'b1;
        @(negedge clk);
        check_val("hs.release.done", 32'(bus.done), 32'h0);
        step();
        @(negedge clk);
        check_val("hs.idle.done", 32'(bus.done), 32'h1);
        check_val("hs.idle.sub_row", 32'(bus.submatrix_row_out), 32'd3);
        check_val("hs.idle.sub_col", 32'(bus.submatrix_col_out), 32'd4);
        check_val("hs.idle.rows", 32'(bus.out_rows_num), 32'd0);
        step();
        @(negedge clk);
        check_val("hs.no_queue.done", 32'(bus.done), 32'h1);
        check_val("hs.no_queue.rd_en", 32'(bus.rd_en), 32'h0);
        step();

        // Reset in FEED cycle 3, outputs must clear without a clock edge
        bus.start = 1'b1; bus.rd_base_addr = 8'h10; bus.vec_last = 2'd3; bus.lane_last = 2'd3;
        bus.submatrix_row_in = 5'd2; bus.submatrix_col_in = 5'd2;
        step();
        bus.start = 1'b0;
        step();
        step();
        check_val("rst.feed3.rd_en", 32'(bus.rd_en), 32'b0111);
        reset = 1'b0;
        #1 check_reset_values("rst.async");
        step();
        reset = 1'b1;
        saw_os = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_start) saw_os = 1'b1;
            step();
        end
        check_val("rst.no_out_start", 32'(saw_os), 32'h0);
        run_vectors(a_lo, a_hi, "replayA");

        // Back-to-back tiles with start held high
        bus.start = 1'b1; bus.rd_base_addr = 8'h30; bus.vec_last = '0; bus.lane_last = '0;
        bus.submatrix_row_in = 5'd1; bus.submatrix_col_in = 5'd2; bus.out_done = 1'b1;
        step();
        bus.rd_base_addr = 8'h50; bus.vec_last = 2'd1; bus.lane_last = 2'd0;
        bus.submatrix_row_in = 5'd7; bus.submatrix_col_in = 5'd9;
        found = 1'b0; held_ok = 1'b1; prev_os = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            bus.out_done = !prev_os;
            @(negedge clk);
            if (bus.done) found = 1'b1;
            else begin
                if (bus.submatrix_row_out !== 5'd1 || bus.submatrix_col_out !== 5'd2) held_ok = 1'b0;
                prev_os = bus.out_start;
                step();
            end
        end
        check_val("b2b.first_done", 32'(found), 32'h1);
        check_val("b2b.held_indices", 32'(held_ok), 32'h1);
        check_val("b2b.idle.sub_row", 32'(bus.submatrix_row_out), 32'd1);
        check_val("b2b.idle.sub_col", 32'(bus.submatrix_col_out), 32'd2);
        step();
        @(negedge clk);
        check_val("b2b.second.done", 32'(bus.done), 32'h0);
        check_val("b2b.second.sub_row", 32'(bus.submatrix_row_out), 32'd7);
        check_val("b2b.second.sub_col", 32'(bus.submatrix_col_out), 32'd9);
        check_val("b2b.second.rows", 32'(bus.out_rows_num), 32'd1);
        check_val("b2b.second.rd_en", 32'(bus.rd_en), 32'b0001);
        check_val("b2b.second.rd_addr", bus.rd_addr, 32'h0000_0050);
        bus.start = 1'b0;
        step();
        found = 1'b0; prev_os = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            bus.out_done = !prev_os;
            @(negedge clk);
            if (bus.done) found = 1'b1;
            else begin prev_os = bus.out_start; step(); end
        end
        check_val("b2b.second_done", 32'(found), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
